// File: rtl/mmu_pkg.sv
// Shared MMU definitions: table geometry defaults, writer register map and
// writer FSM state encoding.
package mmu_pkg;

  localparam int MMU_TASK_BITS  = 4;
  localparam int MMU_VPAGE_BITS = 12;
  localparam int MMU_PPAGE_BITS = 16;

  localparam logic [2:0] REG_TASK  = 3'd0;
  localparam logic [2:0] REG_VPAGE = 3'd1;
  localparam logic [2:0] REG_PPAGE = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_CTRL  = 3'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_INCR  = 1;
  localparam int CTRL_ABORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mmu_table_writer_regs.sv
// Supervisor programming registers for the table writer: TASK/VPAGE/PPAGE/COUNT
// storage with COUNT clamping, plus START/ABORT strobe decode from CTRL writes.
module mmu_table_writer_regs
  import mmu_pkg::*;
#(
  parameter int TASK_BITS  = MMU_TASK_BITS,
  parameter int VPAGE_BITS = MMU_VPAGE_BITS,
  parameter int PPAGE_BITS = MMU_PPAGE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            reg_sel_i,
  input  logic [15:0]           reg_wdata_i,
  input  logic                  reg_we_i,
  input  logic                  busy_i,
  output logic [TASK_BITS-1:0]  tsk_o,
  output logic [VPAGE_BITS-1:0] vpage_o,
  output logic [PPAGE_BITS-1:0] ppage_o,
  output logic [VPAGE_BITS:0]   count_o,
  output logic                  start_o,
  output logic                  incr_o,
  output logic                  abort_o
);

  // One full table's worth of entries is the largest meaningful count.
  localparam logic [VPAGE_BITS:0] MAX_COUNT = {1'b1, {VPAGE_BITS{1'b0}}};

  logic [TASK_BITS-1:0]  tsk_q;
  logic [VPAGE_BITS-1:0] vpage_q;
  logic [PPAGE_BITS-1:0] ppage_q;
  logic [VPAGE_BITS:0]   count_q;
  logic [VPAGE_BITS:0]   count_d;
  logic                  ctrl_wr;

  assign count_d = (reg_wdata_i[VPAGE_BITS:0] > MAX_COUNT) ? MAX_COUNT
                                                           : reg_wdata_i[VPAGE_BITS:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      tsk_q   <= '0;
      vpage_q <= '0;
      ppage_q <= '0;
      count_q <= '0;
    end else if (reg_we_i && !busy_i) begin
      case (reg_sel_i)
        REG_TASK:  tsk_q   <= reg_wdata_i[TASK_BITS-1:0];
        REG_VPAGE: vpage_q <= reg_wdata_i[VPAGE_BITS-1:0];
        REG_PPAGE: ppage_q <= reg_wdata_i[PPAGE_BITS-1:0];
        REG_COUNT: count_q <= count_d;
        default: ;
      endcase
    end
  end

  assign ctrl_wr = reg_we_i && (reg_sel_i == REG_CTRL);
  assign start_o = ctrl_wr && reg_wdata_i[CTRL_START] && !busy_i;
  assign abort_o = ctrl_wr && reg_wdata_i[CTRL_ABORT] && busy_i;
  assign incr_o  = reg_wdata_i[CTRL_INCR];

  assign tsk_o   = tsk_q;
  assign vpage_o = vpage_q;
  assign ppage_o = ppage_q;
  assign count_o = count_q;

endmodule

// File: rtl/mmu_table_writer.sv
// Writer side of the MMU user page-table RAM: commits single, constant-fill or
// incrementing-fill entries, only in cycles where the MMU does not own the bus.
module mmu_table_writer
  import mmu_pkg::*;
#(
  parameter int TASK_BITS  = MMU_TASK_BITS,
  parameter int VPAGE_BITS = MMU_VPAGE_BITS,
  parameter int PPAGE_BITS = MMU_PPAGE_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2:0]                      reg_sel,
  input  logic [15:0]                     reg_wdata,
  input  logic                            reg_we,
  input  logic                            mmu_enable,
  output logic [TASK_BITS+VPAGE_BITS-1:0] ram_addr,
  output logic [PPAGE_BITS-1:0]           ram_data,
  output logic                            ram_we,
  output logic                            busy,
  output logic                            done
);

  localparam logic [VPAGE_BITS:0] REM_LAST = (VPAGE_BITS+1)'(1);

  wr_state_e             state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [TASK_BITS-1:0]  tsk_q;
  logic [VPAGE_BITS-1:0] vpage_q;
  logic [PPAGE_BITS-1:0] ppage_q;
  logic [VPAGE_BITS:0]   rem_q;
  logic                  incr_q;

  logic [TASK_BITS-1:0]  cfg_tsk;
  logic [VPAGE_BITS-1:0] cfg_vpage;
  logic [PPAGE_BITS-1:0] cfg_ppage;
  logic [VPAGE_BITS:0]   cfg_count;
  logic                  start;
  logic                  start_incr;
  logic                  abort;

  mmu_table_writer_regs #(
    .TASK_BITS  (TASK_BITS),
    .VPAGE_BITS (VPAGE_BITS),
    .PPAGE_BITS (PPAGE_BITS)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .reg_sel_i   (reg_sel),
    .reg_wdata_i (reg_wdata),
    .reg_we_i    (reg_we),
    .busy_i      (busy_q),
    .tsk_o       (cfg_tsk),
    .vpage_o     (cfg_vpage),
    .ppage_o     (cfg_ppage),
    .count_o     (cfg_count),
    .start_o     (start),
    .incr_o      (start_incr),
    .abort_o     (abort)
  );

  // ram_we also tristates the RAM bus, so reset and abort must drop it in the
  // same cycle even though state only changes at the next edge.
  assign ram_we   = (state_q == ST_RUN) & ~mmu_enable & ~abort & ~reset;
  assign ram_addr = {tsk_q, vpage_q};
  assign ram_data = ppage_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tsk_q   <= '0;
      vpage_q <= '0;
      ppage_q <= '0;
      rem_q   <= '0;
      incr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_count != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              tsk_q   <= cfg_tsk;
              vpage_q <= cfg_vpage;
              ppage_q <= cfg_ppage;
              rem_q   <= cfg_count;
              incr_q  <= start_incr;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (ram_we) begin
            vpage_q <= vpage_q + 1'b1;
            if (incr_q) ppage_q <= ppage_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            if (rem_q == REM_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          tsk_q   <= '0;
          vpage_q <= '0;
          ppage_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_table_writer.sv
// Self-checking bench for mmu_table_writer: table vectors, hand-written corner
// sequences and randomized operations against a behavioural model.
module tb_mmu_table_writer;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  reg_sel;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        mmu_enable;
  logic [15:0] ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic        busy;
  logic        done;

  mmu_table_writer dut (
    .clk        (clk),
    .reset      (reset),
    .reg_sel    (reg_sel),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .mmu_enable (mmu_enable),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .ram_we     (ram_we),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];

  // Model copy of the programming registers.
  logic [3:0]  m_tsk;
  logic [11:0] m_vp;
  logic [15:0] m_pp;
  int          m_cnt;
  int          g_done_at;

  typedef struct {
    logic [3:0]  tsk;
    logic [11:0] vp;
    logic [15:0] pp;
    logic [15:0] cnt;
    logic        incr;
    int          exp_writes;
    logic [15:0] f_addr;
    logic [15:0] f_data;
    logic [15:0] l_addr;
    logic [15:0] l_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [15:0] d);
    reg_sel   = sel;
    reg_wdata = d;
    reg_we    = 1'b1;
    @(posedge clk); #1;
    reg_we    = 1'b0;
  endtask

  task automatic program_regs(input logic [3:0] tsk, input logic [11:0] vp,
                              input logic [15:0] pp, input logic [15:0] cnt);
    int c;
    reg_write(REG_TASK, {12'h000, tsk});
    reg_write(REG_VPAGE, {4'h0, vp});
    reg_write(REG_PPAGE, pp);
    reg_write(REG_COUNT, cnt);
    c = int'(cnt & 16'h1FFF);
    m_tsk = tsk;
    m_vp  = vp;
    m_pp  = pp;
    m_cnt = (c > 4096) ? 4096 : c;
  endtask

  // stall_mode: 0 none, 1 mmu_enable high in cycles 2-3, 2 random.
  task automatic run_op(input string name, input logic incr, input int stall_mode,
                        input int abort_at, input int reset_at, input int busywr_at);
    logic        stall[$];
    int          budget, exp_done, w, last_k, done_at, done_n;
    logic        busy1;
    logic [11:0] vp;
    logic [15:0] pp;
    budget   = 3 * m_cnt + 20;
    exp_done = 0;
    w        = 0;
    done_at  = 0;
    done_n   = 0;
    busy1    = 1'b0;
    exp_q.delete();
    act_q.delete();
    for (int k = 0; k <= budget + 4; k++) begin
      if (stall_mode == 1)      stall.push_back(k == 2 || k == 3);
      else if (stall_mode == 2) stall.push_back($urandom_range(0, 3) == 0);
      else                      stall.push_back(1'b0);
    end
    if (m_cnt == 0) exp_done = 1;
    else begin
      for (int k = 1; k <= budget; k++) begin
        if (k == reset_at) break;
        if (k == abort_at) begin exp_done = k + 1; break; end
        if (!stall[k]) begin
          vp = m_vp + 12'(w);
          pp = incr ? m_pp + 16'(w) : m_pp;
          exp_q.push_back({m_tsk, vp, pp});
          w++;
          if (w == m_cnt) begin exp_done = k + 1; break; end
        end
      end
    end
    last_k = (exp_done != 0) ? exp_done + 2 : reset_at + 2;

    reg_write(REG_CTRL, {13'h0000, 1'b0, incr, 1'b1});
    for (int k = 1; k <= last_k; k++) begin
      mmu_enable = stall[k];
      if (k == abort_at) begin reg_sel = REG_CTRL; reg_wdata = 16'h0004; reg_we = 1'b1; end
      if (k == busywr_at) begin reg_sel = REG_VPAGE; reg_wdata = 16'h0ABC; reg_we = 1'b1; end
      if (k == reset_at) reset = 1'b1;
      @(negedge clk);
      if (ram_we) act_q.push_back({ram_addr, ram_data});
      if (done) begin done_n++; if (done_at == 0) done_at = k; end
      if (k == 1) busy1 = busy;
      if (k == reset_at) check($sformatf("%s ram_we_in_reset", name), 32'(ram_we), 32'd0);
      @(posedge clk); #1;
      reg_we     = 1'b0;
      reset      = 1'b0;
      mmu_enable = 1'b0;
    end

    check($sformatf("%s write_count", name), act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s entry%0d", name, i), act_q[i], exp_q[i]);
    check($sformatf("%s done_pulses", name), done_n, (exp_done != 0) ? 1 : 0);
    check($sformatf("%s done_cycle", name), done_at, exp_done);
    check($sformatf("%s busy_first", name), 32'(busy1), (m_cnt > 0) ? 32'd1 : 32'd0);
    check($sformatf("%s busy_after", name), 32'(busy), 32'd0);
    if (reset_at != 0) begin
      m_tsk = '0; m_vp = '0; m_pp = '0; m_cnt = 0;
    end
    g_done_at = done_at;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reg_sel = '0; reg_wdata = '0; reg_we = 1'b0; mmu_enable = 1'b0;
    m_tsk = '0; m_vp = '0; m_pp = '0; m_cnt = 0; g_done_at = 0;

    vecs[0] = '{4'h1, 12'h002, 16'h8000, 16'd1,    1'b0, 1,    16'h1002, 16'h8000, 16'h1002, 16'h8000};
    vecs[1] = '{4'h4, 12'h010, 16'h0300, 16'd4,    1'b1, 4,    16'h4010, 16'h0300, 16'h4013, 16'h0303};
    vecs[2] = '{4'h2, 12'hFFE, 16'h1234, 16'd3,    1'b0, 3,    16'h2FFE, 16'h1234, 16'h2000, 16'h1234};
    vecs[3] = '{4'h7, 12'h000, 16'hFFFE, 16'd3,    1'b1, 3,    16'h7000, 16'hFFFE, 16'h7002, 16'h0000};
    vecs[4] = '{4'h3, 12'h800, 16'h0010, 16'hFFFF, 1'b1, 4096, 16'h3800, 16'h0010, 16'h37FF, 16'h100F};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check("reset ram_addr", 32'(ram_addr), 32'd0);
    check("reset ram_data", 32'(ram_data), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      program_regs(vecs[i].tsk, vecs[i].vp, vecs[i].pp, vecs[i].cnt);
      run_op($sformatf("vec%0d", i), vecs[i].incr, 0, 0, 0, 0);
      check($sformatf("vec%0d table_writes", i), act_q.size(), vecs[i].exp_writes);
      check($sformatf("vec%0d table_latency", i), g_done_at, vecs[i].exp_writes + 1);
      if (act_q.size() > 0) begin
        check($sformatf("vec%0d first", i), act_q[0], {vecs[i].f_addr, vecs[i].f_data});
        check($sformatf("vec%0d last", i), act_q[act_q.size()-1], {vecs[i].l_addr, vecs[i].l_data});
      end
    end

    program_regs(4'h5, 12'h100, 16'h0A00, 16'd3);
    run_op("contention", 1'b1, 1, 0, 0, 0);
    check("contention latency", g_done_at, 6);

    program_regs(4'h6, 12'h000, 16'h0000, 16'd0);
    run_op("count0", 1'b0, 0, 0, 0, 0);

    program_regs(4'h8, 12'h020, 16'h5555, 16'd4096);
    run_op("abort", 1'b1, 0, 6, 0, 0);
    check("abort writes", act_q.size(), 5);

    program_regs(4'h9, 12'h0F0, 16'h0100, 16'd6);
    run_op("busy_write", 1'b0, 0, 0, 0, 2);
    run_op("repeat_start", 1'b0, 0, 0, 0, 0);
    check("repeat first", (act_q.size() > 0) ? act_q[0] : 32'hDEAD_BEEF, 32'h90F0_0100);

    program_regs(4'hA, 12'h300, 16'h0777, 16'd10);
    run_op("reset_mid", 1'b1, 0, 0, 4, 0);
    check("reset_mid writes", act_q.size(), 3);
    run_op("after_reset", 1'b1, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      automatic logic [15:0] cnt = 16'($urandom_range(1, 40));
      automatic int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(cnt)) : 0;
      program_regs(4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)),
                   16'($urandom_range(0, 65535)), cnt);
      run_op($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 2, ab, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
